// File: rtl/clock_set_ctrl.sv
// Mode/setting sequencer: turns debounced mode/inc buttons into run enable, field select,
// increment strobes and field blink. Define CLOCK_SET_AUTO_REPEAT_EN for held-inc auto-repeat.
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned BLINK_CYCLES   = 250,
    parameter int unsigned HOLD_CYCLES    = 500,
    parameter int unsigned REPEAT_CYCLES  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       run_en,
    output logic [1:0] set_sel,
    output logic       hr_inc,
    output logic       min_inc,
    output logic       blink
);
    localparam int unsigned IdleW  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StSetHr  = 2'b01,
        StSetMin = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              mode_q, inc_q;
    logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic              blink_q, blink_d;
    logic              run_en_q, run_en_d;
    logic              hr_inc_q, hr_inc_d;
    logic              min_inc_q, min_inc_d;
    logic              mode_rise, inc_rise, in_set, state_chg, timeout, strobe, rep_fire;

    assign mode_rise = mode_btn & ~mode_q;
    assign inc_rise  = inc_btn & ~inc_q;
    assign in_set    = (state_q == StSetHr) || (state_q == StSetMin);
    // A rise of either button in the timeout cycle counts as activity and cancels the exit.
    assign timeout   = (idle_cnt_q == IdleW'(TIMEOUT_CYCLES - 1)) && !inc_rise;
    assign state_chg = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (mode_rise) state_d = StSetHr;
            end
            StSetHr: begin
                if (mode_rise)    state_d = StSetMin;
                else if (timeout) state_d = StRun;
            end
            StSetMin: begin
                if (mode_rise)    state_d = StRun;
                else if (timeout) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int unsigned RepMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    // rep_cnt_q == 0 means not armed; rep_phase_q selects the hold or repeat interval.
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_phase_q, rep_phase_d;

    always_comb begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_fire    = 1'b0;
        if (in_set && !mode_rise && !state_chg) begin
            if (inc_rise) begin
                rep_cnt_d = RepW'(1);
            end else if (inc_btn && (rep_cnt_q != '0)) begin
                rep_phase_d = rep_phase_q;
                if (rep_cnt_q == (rep_phase_q ? RepW'(REPEAT_CYCLES) : RepW'(HOLD_CYCLES))) begin
                    rep_fire    = 1'b1;
                    rep_cnt_d   = RepW'(1);
                    rep_phase_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`else
    logic [31:0] unused_repeat_cfg;
    assign unused_repeat_cfg = HOLD_CYCLES + REPEAT_CYCLES;
    assign rep_fire          = 1'b0;
`endif

    assign strobe = in_set && !mode_rise && (inc_rise || rep_fire);

    always_comb begin
        hr_inc_d  = strobe && (state_q == StSetHr);
        min_inc_d = strobe && (state_q == StSetMin);
        run_en_d  = (state_d == StRun);

        if (!in_set || mode_rise || inc_rise || rep_fire) idle_cnt_d = '0;
        else                                              idle_cnt_d = idle_cnt_q + 1'b1;

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (state_chg) begin
            blink_cnt_d   = '0;
            blink_phase_d = (state_d != StRun);
        end else if (!in_set) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
        // Force the field visible for the cycle after a strobe without disturbing the phase.
        blink_d = (state_d != StRun) && (blink_phase_d || hr_inc_q || min_inc_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            mode_q        <= 1'b1;
            inc_q         <= 1'b1;
            idle_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blink_q       <= 1'b0;
            run_en_q      <= 1'b1;
            hr_inc_q      <= 1'b0;
            min_inc_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_btn;
            inc_q         <= inc_btn;
            idle_cnt_q    <= idle_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            blink_q       <= blink_d;
            run_en_q      <= run_en_d;
            hr_inc_q      <= hr_inc_d;
            min_inc_q     <= min_inc_d;
        end
    end

    assign set_sel = state_q;
    assign run_en  = run_en_q;
    assign hr_inc  = hr_inc_q;
    assign min_inc = min_inc_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: cycle model from the behavioural rules plus directed literal checks.
module tb_clock_set_ctrl;
    localparam int T = 20;
    localparam int B = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b1;
    logic       inc_btn = 1'b1;
    logic       run_en, hr_inc, min_inc, blink;
    logic [1:0] set_sel;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hr_total = 0;
    int min_total = 0;
    int strobe_q[$];

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .TIMEOUT_CYCLES(T),
        .BLINK_CYCLES  (B),
        .HOLD_CYCLES   (H),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode_btn(mode_btn),
        .inc_btn (inc_btn),
        .run_en  (run_en),
        .set_sel (set_sel),
        .hr_inc  (hr_inc),
        .min_inc (min_inc),
        .blink   (blink)
    );

    // Model state: field 0=run,1=hour,2=minute; ticks = cycles since entering the state;
    // m_ht = edges the inc button has been held since its rise (-1 when not held).
    int m_state, m_idle, m_ticks, m_ht;
    bit m_pm, m_pi, m_hr, m_min, m_run, m_blink;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        bit mr, ir, fire, rfire, sprev;
        int nxt;
        cyc++;
        if (rst) begin
            m_state = 0; m_pm = 1; m_pi = 1; m_idle = 0; m_ticks = 0; m_ht = -1;
            m_hr = 0; m_min = 0; m_run = 1; m_blink = 0;
        end else begin
            mr    = mode_btn && !m_pm;
            ir    = inc_btn && !m_pi;
            sprev = m_hr || m_min;
            nxt   = m_state;
            if (mr) nxt = (m_state + 1) % 3;
            else if (m_state != 0 && m_idle == T - 1 && !ir) nxt = 0;
            fire  = (m_state != 0) && !mr && ir;
            rfire = 0;
            if (fire) m_ht = 0;
            else if (m_ht >= 0 && inc_btn && m_state != 0 && nxt == m_state) begin
                m_ht++;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
                if (m_ht >= H && (m_ht - H) % R == 0) rfire = 1;
`endif
            end else m_ht = -1;
            m_idle  = (m_state == 0 || mr || ir || rfire) ? 0 : m_idle + 1;
            m_hr    = (fire || rfire) && m_state == 1;
            m_min   = (fire || rfire) && m_state == 2;
            m_ticks = (nxt != m_state) ? 0 : m_ticks + 1;
            m_blink = (nxt != 0) && (((m_ticks / B) % 2 == 0) || sprev);
            m_state = nxt;
            m_run   = (nxt == 0);
            m_pm    = mode_btn;
            m_pi    = inc_btn;
        end
        #1;
        n_cmp++;
        if (set_sel !== 2'(m_state) || run_en !== m_run || hr_inc !== m_hr ||
            min_inc !== m_min || blink !== m_blink) begin
            n_err++;
            $display("FAIL cycle %0d outputs: got sel=%0d run=%0b hr=%0b min=%0b blink=%0b, expected sel=%0d run=%0b hr=%0b min=%0b blink=%0b",
                     cyc, set_sel, run_en, hr_inc, min_inc, blink,
                     m_state, m_run, m_hr, m_min, m_blink);
        end
        if (hr_inc === 1'b1) hr_total++;
        if (min_inc === 1'b1) min_total++;
        if (hr_inc === 1'b1 || min_inc === 1'b1) strobe_q.push_back(cyc);
    end

    task automatic press_mode();
        mode_btn = 1'b1;
        @(negedge clk);
        mode_btn = 1'b0;
    endtask

    task automatic press_inc(output int drv);
        drv = cyc;
        inc_btn = 1'b1;
        @(negedge clk);
        inc_btn = 1'b0;
    endtask

    initial begin
        int d, base_hr, base_min, n;
        int drv_q[$];
        int exp_off[5];
        logic [19:0] bpat;
        bit sel_held;
        exp_off = '{1, 11, 14, 17, 20};

        // Reset with both buttons held, then release.
        repeat (3) @(negedge clk);
        chk("reset_run_en", run_en, 1);
        chk("reset_set_sel", set_sel, 0);
        chk("reset_blink", blink, 0);
        chk("reset_strobes", hr_inc + min_inc, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_thru_reset_sel", set_sel, 0);
        chk("held_thru_reset_run", run_en, 1);
        chk("held_thru_reset_strobes", hr_total + min_total, 0);

        // Hour field: three presses.
        press_mode();
        repeat (3) @(negedge clk);
        chk("set_hr_sel", set_sel, 1);
        chk("set_hr_run_en", run_en, 0);
        base_hr = hr_total; base_min = min_total;
        strobe_q.delete();
        for (int i = 0; i < 3; i++) begin
            press_inc(d);
            drv_q.push_back(d);
            repeat (5) @(negedge clk);
        end
        chk("hr_pulse_count", hr_total - base_hr, 3);
        chk("hr_no_min", min_total - base_min, 0);
        chk("hr_strobe_records", strobe_q.size(), 3);
        if (strobe_q.size() == 3)
            for (int i = 0; i < 3; i++) chk("hr_latency", strobe_q[i] - drv_q[i], 1);

        // Minute field: two presses, then back to run.
        press_mode();
        repeat (3) @(negedge clk);
        chk("set_min_sel", set_sel, 2);
        base_hr = hr_total; base_min = min_total;
        for (int i = 0; i < 2; i++) begin
            press_inc(d);
            repeat (5) @(negedge clk);
        end
        chk("min_pulse_count", min_total - base_min, 2);
        chk("min_no_hr", hr_total - base_hr, 0);
        press_mode();
        repeat (2) @(negedge clk);
        chk("back_to_run_sel", set_sel, 0);
        chk("back_to_run_en", run_en, 1);

        // Idle timeout in the minute field with blink pattern.
        press_mode();
        repeat (2) @(negedge clk);
        press_mode();
        sel_held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bpat[19-i] = blink;
            if (set_sel !== 2'd2) sel_held = 1'b0;
            @(negedge clk);
        end
        chk("timeout_stays_20", sel_held, 1);
        chk("timeout_exit_sel", set_sel, 0);
        chk("timeout_exit_run", run_en, 1);
        chk("blink_pattern", bpat, 20'hF0F0F);

        // Simultaneous rises in the hour field: mode wins, no strobe.
        press_mode();
        repeat (3) @(negedge clk);
        base_hr = hr_total; base_min = min_total;
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        @(negedge clk);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        repeat (3) @(negedge clk);
        chk("simul_sel", set_sel, 2);
        chk("simul_no_strobe", (hr_total - base_hr) + (min_total - base_min), 0);
        press_mode();
        repeat (2) @(negedge clk);
        chk("simul_exit_sel", set_sel, 0);

        // Held inc for 20 cycles in the hour field.
        press_mode();
        repeat (3) @(negedge clk);
        strobe_q.delete();
        d = cyc;
        inc_btn = 1'b1;
        repeat (20) @(negedge clk);
        inc_btn = 1'b0;
        repeat (3) @(negedge clk);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        n = 5;
`else
        n = 1;
`endif
        chk("hold_strobe_count", strobe_q.size(), n);
        if (strobe_q.size() == n)
            for (int i = 0; i < n; i++) chk("hold_strobe_offset", strobe_q[i] - d, exp_off[i]);
        repeat (25) @(negedge clk);
        chk("hold_timeout_sel", set_sel, 0);

        // Reset while a strobe is on the output.
        press_mode();
        repeat (2) @(negedge clk);
        inc_btn = 1'b1;
        @(negedge clk);
        chk("strobe_before_reset", hr_inc, 1);
        rst = 1'b1;
        inc_btn = 1'b0;
        @(negedge clk);
        chk("reset_drops_strobe", hr_inc, 0);
        chk("reset_mid_sel", set_sel, 0);
        chk("reset_mid_run", run_en, 1);
        chk("reset_mid_blink", blink, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("after_reset_sel", set_sel, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
